// File: rtl/mfp_adc_max10_sample_fifo.sv
// Sample FIFO behind the MAX10 ADC response stream, drained through a register port.
// Buffers tagged conversion results and raises a level/overflow interrupt.
module mfp_adc_max10_sample_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ADC_R_Valid,
  input  logic [4:0]            ADC_R_Channel,
  input  logic [11:0]           ADC_R_Data,
  input  logic                  ADC_R_SOP,
  input  logic                  ADC_R_EOP,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_enable,
  output logic [31:0]           read_data,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [31:0]           write_data,
  input  logic                  write_enable,
  output logic                  FIFO_Interrupt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic                  r_en, r_ie, r_ovf, r_irq;
  logic [7:0]            r_thr;
  logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [18:0]           r_mem [DEPTH];

  logic                  w_en_nxt, w_ie_nxt, w_ovf_nxt, w_irq_nxt;
  logic [7:0]            w_thr_nxt;
  logic [DEPTH_LOG2-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_full, w_empty, w_fcs_wr, w_clr;
  logic                  w_push_req, w_push, w_pop, w_ovf_set;
  logic [18:0]           w_head;
  logic                  w_unused_wdata;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_fcs_wr   = write_enable && (write_addr == ADDR_WIDTH'(0));
  assign w_clr      = w_fcs_wr && write_data[1];
  assign w_pop      = read_enable && (read_addr == ADDR_WIDTH'(1)) && !w_empty;
  assign w_push_req = ADC_R_Valid && r_en;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_ovf_set  = w_push_req && w_full && !w_pop;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_unused_wdata = ^{write_data[31:16], write_data[7:4]};

  always_comb begin
    w_en_nxt     = r_en;
    w_ie_nxt     = r_ie;
    w_thr_nxt    = r_thr;
    w_ovf_nxt    = r_ovf;
    w_count_nxt  = r_count;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_fcs_wr && !write_data[1]) begin
      w_en_nxt  = write_data[0];
      w_ie_nxt  = write_data[2];
      w_thr_nxt = write_data[15:8];
    end
    if (w_clr) begin
      w_ovf_nxt    = 1'b0;
      w_count_nxt  = '0;
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end else begin
      if (w_ovf_set)
        w_ovf_nxt = 1'b1;
      else if (w_fcs_wr && write_data[3])
        w_ovf_nxt = 1'b0;
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + 1'b1;
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + 1'b1;
        2'b01:   w_count_nxt = r_count - 1'b1;
        default: w_count_nxt = r_count;
      endcase
    end
    w_irq_nxt = w_ie_nxt && (w_ovf_nxt ||
                ((w_thr_nxt != 8'd0) && (9'(w_count_nxt) >= 9'(w_thr_nxt))));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_en     <= 1'b0;
      r_ie     <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
      r_thr    <= '0;
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_en     <= w_en_nxt;
      r_ie     <= w_ie_nxt;
      r_ovf    <= w_ovf_nxt;
      r_irq    <= w_irq_nxt;
      r_thr    <= w_thr_nxt;
      r_count  <= w_count_nxt;
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push && !w_clr && !RESET)
      r_mem[r_wr_ptr] <= {ADC_R_SOP, ADC_R_EOP, ADC_R_Channel, ADC_R_Data};
  end

  always_comb begin
    read_data = '0;
    if (read_addr == ADDR_WIDTH'(0))
      read_data = {7'b0, 9'(r_count), r_thr, 2'b0, w_full, w_empty, r_ovf, r_ie, 1'b0, r_en};
    else if ((read_addr == ADDR_WIDTH'(1)) && !w_empty)
      read_data = {1'b1, w_head[18], w_head[17], 8'b0, w_head[16:12], 4'b0, w_head[11:0]};
  end

  assign FIFO_Interrupt = r_irq;

endmodule
